// File: rtl/store_buffer.sv
// Store buffer between the MEM stage and dmemory: FIFO of pending stores drained one per cycle,
// with youngest-entry load forwarding and a two-cycle registered-address miss path.
module store_buffer #(
   parameter int DEPTH = 4,
   parameter int AW    = 16,
   parameter int DW    = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_st,
   input  logic          req_ld,
   input  logic [AW-1:0] req_addr,
   input  logic [DW-1:0] req_wdata,
   input  logic          drain_hold,
   output logic          stall,
   output logic          ld_valid,
   output logic [DW-1:0] ld_data,
   output logic          buf_empty,
   output logic          mem_write,
   output logic          mem_read,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      LD_WAIT = 1'b1
   } state_t;

   state_t          state_r;
   logic [AW-1:0]   addr_r [DEPTH];
   logic [DW-1:0]   data_r [DEPTH];
   logic [PW-1:0]   head_r;
   logic [PW-1:0]   tail_r;
   logic [CW-1:0]   count_r;
   logic [AW-1:0]   ld_addr_r;

   logic            full_s;
   logic            st_acc_s;
   logic            ld_req_s;
   logic            hit_s;
   logic [DW-1:0]   fwd_s;
   logic [PW-1:0]   idx_s;
   logic            miss_s;
   logic            drain_s;

   assign full_s    = (count_r == CW'(DEPTH));
   assign st_acc_s  = req_st & ~full_s & (state_r == IDLE);
   assign ld_req_s  = req_ld & ~req_st & (state_r == IDLE);
   assign miss_s    = ld_req_s & ~hit_s;
   assign drain_s   = (count_r != {CW{1'b0}}) & ~drain_hold & ~miss_s;
   assign buf_empty = (count_r == {CW{1'b0}});

   // Forwarding search: walk oldest to youngest so the last match is the youngest entry.
   always_comb begin
      hit_s = 1'b0;
      fwd_s = {DW{1'b0}};
      idx_s = {PW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
         idx_s = head_r + PW'(i);
         if ((CW'(i) < count_r) && (addr_r[idx_s] == req_addr)) begin
            hit_s = 1'b1;
            fwd_s = data_r[idx_s];
         end else begin
            hit_s = hit_s;
         end
      end
   end

   // Port drive: a miss-load address cycle owns the address bus, otherwise the head entry drains.
   always_comb begin
      stall     = 1'b0;
      mem_write = 1'b0;
      mem_read  = 1'b0;
      mem_addr  = {AW{1'b0}};
      mem_wdata = {DW{1'b0}};
      if (!rst) begin
         stall = 1'b0;
      end else begin
         stall     = (req_st & full_s) | (state_r == LD_WAIT);
         mem_write = drain_s;
         mem_read  = miss_s | (state_r == LD_WAIT);
         mem_wdata = drain_s ? data_r[head_r] : {DW{1'b0}};
         if (miss_s) begin
            mem_addr = req_addr;
         end else if (drain_s) begin
            mem_addr = addr_r[head_r];
         end else if (state_r == LD_WAIT) begin
            mem_addr = ld_addr_r;
         end else begin
            mem_addr = {AW{1'b0}};
         end
      end
   end

   // Store queue storage and pointers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_r  <= {PW{1'b0}};
         tail_r  <= {PW{1'b0}};
         count_r <= {CW{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            addr_r[i] <= {AW{1'b0}};
            data_r[i] <= {DW{1'b0}};
         end
      end else begin
         if (st_acc_s) begin
            addr_r[tail_r] <= req_addr;
            data_r[tail_r] <= req_wdata;
            tail_r         <= tail_r + PW'(1);
         end
         if (drain_s) begin
            head_r <= head_r + PW'(1);
         end
         count_r <= count_r + CW'(st_acc_s) - CW'(drain_s);
      end
   end

   // Load FSM: forwarded hits complete in one cycle, misses wait one cycle for dmemory data.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r   <= IDLE;
         ld_addr_r <= {AW{1'b0}};
         ld_valid  <= 1'b0;
         ld_data   <= {DW{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (miss_s) begin
                  state_r   <= LD_WAIT;
                  ld_addr_r <= req_addr;
                  ld_valid  <= 1'b0;
               end else if (ld_req_s) begin
                  ld_valid <= 1'b1;
                  ld_data  <= fwd_s;
               end else begin
                  ld_valid <= 1'b0;
               end
            end
            LD_WAIT: begin
               state_r  <= IDLE;
               ld_valid <= 1'b1;
               ld_data  <= mem_rdata;
            end
            default: begin
               state_r  <= IDLE;
               ld_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed vector table, hand-written corner sequences and a randomized
// run checked against a queue-based reference model plus an attached dmemory model.
module tb_store_buffer;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_st, req_ld, drain_hold;
   logic [15:0] req_addr, req_wdata;
   logic        stall, ld_valid, buf_empty, mem_write, mem_read;
   logic [15:0] ld_data, mem_addr, mem_wdata, mem_rdata;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   store_buffer #(.DEPTH(DEPTH), .AW(16), .DW(16)) dut (
      .clk(clk), .rst(rst), .req_st(req_st), .req_ld(req_ld), .req_addr(req_addr),
      .req_wdata(req_wdata), .drain_hold(drain_hold), .stall(stall), .ld_valid(ld_valid),
      .ld_data(ld_data), .buf_empty(buf_empty), .mem_write(mem_write), .mem_read(mem_read),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   function automatic logic [15:0] pat(input int i);
      logic [15:0] v;
      v = 16'(i) * 16'h0101;
      return (i == 48) ? 16'h5A5A : (v ^ 16'hC35A);
   endfunction

   // dmemory: registered read address, write on posedge, preloaded while in reset
   logic [15:0] dmem [256];
   logic [7:0]  dmem_raddr;
   logic [15:0] wlog [$];
   assign mem_rdata = dmem[dmem_raddr];

   always @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 256; i++) dmem[i] <= pat(i);
         dmem_raddr <= 8'h00;
      end else begin
         if (mem_write) begin
            dmem[mem_addr[7:0]] <= mem_wdata;
            wlog.push_back(mem_addr);
         end
         if (mem_read) dmem_raddr <= mem_addr[7:0];
      end
   end

   // reference model
   typedef struct {
      logic [15:0] a;
      logic [15:0] d;
   } ent_t;
   ent_t        q [$];
   bit          m_wait;
   logic [15:0] m_waddr;
   bit          m_ldv;
   logic [15:0] m_ldd;
   logic [15:0] ref_mem [256];

   // combinational outputs sampled in the last cycle
   logic        s_write, s_read, s_stall;
   logic [15:0] s_addr, s_wdata;

   task automatic model_reset();
      q.delete();
      m_wait  = 1'b0;
      m_waddr = 16'h0000;
      m_ldv   = 1'b0;
      m_ldd   = 16'h0000;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic cyc(input logic st, input logic ld, input logic [15:0] a, input logic [15:0] d,
                      input logic hold);
      bit          hit, miss, drn, acc;
      logic [15:0] fwd;
      int          n;
      @(negedge clk);
      req_st = st; req_ld = ld; req_addr = a; req_wdata = d; drain_hold = hold;
      #1;
      s_write = mem_write; s_read = mem_read; s_stall = stall; s_addr = mem_addr; s_wdata = mem_wdata;
      n   = q.size();
      hit = 1'b0;
      fwd = 16'h0000;
      if (!m_wait && ld && !st) begin
         for (int i = 0; i < n; i++) begin
            if (q[i].a == a) begin
               hit = 1'b1;
               fwd = q[i].d;
            end
         end
      end
      miss = !m_wait && ld && !st && !hit;
      drn  = (n > 0) && !hold && !miss;
      acc  = st && (n < DEPTH) && !m_wait;
      chk("stall", stall, 32'((st && n == DEPTH) || m_wait));
      chk("mem_write", mem_write, 32'(drn));
      chk("mem_read", mem_read, 32'(miss || m_wait));
      if (drn) begin
         chk("drain_addr", mem_addr, 32'(q[0].a));
         chk("drain_data", mem_wdata, 32'(q[0].d));
      end
      if (miss) chk("miss_addr", mem_addr, 32'(a));
      @(posedge clk);
      #1;
      if (m_wait) begin
         m_ldv = 1'b1;
         m_ldd = ref_mem[m_waddr[7:0]];
      end else if (hit) begin
         m_ldv = 1'b1;
         m_ldd = fwd;
      end else begin
         m_ldv = 1'b0;
      end
      if (drn) begin
         ref_mem[q[0].a[7:0]] = q[0].d;
         void'(q.pop_front());
      end
      if (acc) q.push_back('{a, d});
      m_wait = miss;
      if (miss) m_waddr = a;
      chk("ld_valid", ld_valid, 32'(m_ldv));
      chk("ld_data", ld_data, 32'(m_ldd));
      chk("buf_empty", buf_empty, 32'(q.size() == 0));
   endtask

   typedef struct {
      logic st, ld;
      logic [15:0] a, d;
      logic hold, e_wr, e_rd;
      logic [15:0] e_addr, e_wd;
      logic e_stall, e_ldv;
      logic [15:0] e_ldd;
      logic e_empty;
   } vec_t;

   function automatic vec_t mk(input logic st, input logic ld, input logic [15:0] a,
                               input logic [15:0] d, input logic hold, input logic wr,
                               input logic rd, input logic [15:0] ea, input logic [15:0] ewd,
                               input logic es, input logic elv, input logic [15:0] eld,
                               input logic ee);
      vec_t v;
      v = '{st, ld, a, d, hold, wr, rd, ea, ewd, es, elv, eld, ee};
      return v;
   endfunction

   initial begin
      vec_t tv [10];
      int   w0;
      tv[0] = mk(1'b1, 1'b0, 16'h0010, 16'hABCD, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);
      tv[1] = mk(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0010, 16'hABCD, 1'b0, 1'b0, 16'h0000, 1'b1);
      tv[2] = mk(1'b1, 1'b0, 16'h0020, 16'h1111, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);
      tv[3] = mk(1'b1, 1'b0, 16'h0020, 16'h2222, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);
      tv[4] = mk(1'b0, 1'b1, 16'h0020, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h2222, 1'b0);
      tv[5] = mk(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0020, 16'h1111, 1'b0, 1'b0, 16'h2222, 1'b0);
      tv[6] = mk(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0020, 16'h2222, 1'b0, 1'b0, 16'h2222, 1'b1);
      tv[7] = mk(1'b0, 1'b1, 16'h0030, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0030, 16'h0000, 1'b0, 1'b0, 16'h2222, 1'b1);
      tv[8] = mk(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h5A5A, 1'b1);
      tv[9] = mk(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h5A5A, 1'b1);

      for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
      model_reset();
      rst = 1'b0; req_st = 1'b1; req_ld = 1'b0; req_addr = 16'h0010; req_wdata = 16'h1234;
      drain_hold = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_stall", stall, 32'd0);
      chk("rst_mem_write", mem_write, 32'd0);
      chk("rst_mem_read", mem_read, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_ld_valid", ld_valid, 32'd0);
      chk("rst_ld_data", ld_data, 32'd0);
      chk("rst_buf_empty", buf_empty, 32'd1);
      @(negedge clk);
      req_st = 1'b0;
      rst = 1'b1;

      // directed table: store/drain, forwarding from youngest, miss-load timing
      for (int i = 0; i < 10; i++) begin
         cyc(tv[i].st, tv[i].ld, tv[i].a, tv[i].d, tv[i].hold);
         chk($sformatf("tv%0d_write", i), s_write, 32'(tv[i].e_wr));
         chk($sformatf("tv%0d_read", i), s_read, 32'(tv[i].e_rd));
         chk($sformatf("tv%0d_stall", i), s_stall, 32'(tv[i].e_stall));
         if (tv[i].e_wr || (tv[i].e_rd && !tv[i].e_stall))
            chk($sformatf("tv%0d_addr", i), s_addr, 32'(tv[i].e_addr));
         if (tv[i].e_wr) chk($sformatf("tv%0d_wdata", i), s_wdata, 32'(tv[i].e_wd));
         chk($sformatf("tv%0d_ldv", i), ld_valid, 32'(tv[i].e_ldv));
         chk($sformatf("tv%0d_ldd", i), ld_data, 32'(tv[i].e_ldd));
         chk($sformatf("tv%0d_empty", i), buf_empty, 32'(tv[i].e_empty));
      end

      // full buffer, stalled 5th store, ordered drain with pointer wrap
      w0 = wlog.size();
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 16'h0040 + 16'(i), 16'h1000 + 16'(i), 1'b1);
      cyc(1'b1, 1'b0, 16'h0044, 16'h1004, 1'b1);
      chk("t4_full_stall", s_stall, 32'd1);
      cyc(1'b1, 1'b0, 16'h0044, 16'h1004, 1'b0);
      chk("t4_drain_full_stall", s_stall, 32'd1);
      cyc(1'b1, 1'b0, 16'h0044, 16'h1004, 1'b0);
      chk("t4_accept_stall", s_stall, 32'd0);
      repeat (6) cyc(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      chk("t4_write_count", wlog.size() - w0, 32'd5);
      for (int i = 0; i < 5; i++)
         if (w0 + i < wlog.size()) chk($sformatf("t4_order%0d", i), wlog[w0 + i], 32'h40 + 32'(i));

      // drain pauses only in the miss address cycle
      cyc(1'b1, 1'b0, 16'h0060, 16'h6060, 1'b1);
      cyc(1'b1, 1'b0, 16'h0061, 16'h6161, 1'b1);
      cyc(1'b0, 1'b1, 16'h0050, 16'h0000, 1'b0);
      chk("t5_addr_cycle_write", s_write, 32'd0);
      chk("t5_addr_cycle_read", s_read, 32'd1);
      cyc(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      chk("t5_wait_write", s_write, 32'd1);
      chk("t5_wait_addr", s_addr, 32'h0060);
      chk("t5_wait_stall", s_stall, 32'd1);
      chk("t5_ld_valid", ld_valid, 32'd1);
      chk("t5_ld_data", ld_data, 32'(pat(16'h0050)));
      cyc(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      chk("t5_resume_addr", s_addr, 32'h0061);

      // async reset mid-cycle discards pending stores
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 16'h0070 + 16'(i), 16'h7000 + 16'(i), 1'b1);
      cyc(1'b0, 1'b1, 16'h0071, 16'h0000, 1'b1);
      chk("t6_pre_ldv", ld_valid, 32'd1);
      @(negedge clk);
      req_st = 1'b1; req_ld = 1'b0; req_addr = 16'h0073; drain_hold = 1'b0;
      rst = 1'b0;
      #1;
      chk("t6_stall", stall, 32'd0);
      chk("t6_mem_write", mem_write, 32'd0);
      chk("t6_mem_read", mem_read, 32'd0);
      chk("t6_ld_valid", ld_valid, 32'd0);
      chk("t6_ld_data", ld_data, 32'd0);
      chk("t6_buf_empty", buf_empty, 32'd1);
      #1;
      rst = 1'b1;
      req_st = 1'b0;
      model_reset();
      w0 = wlog.size();
      repeat (5) cyc(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      chk("t6_no_write", wlog.size() - w0, 32'd0);

      // randomized traffic on a small address window to get frequent hits
      for (int k = 0; k < 500; k++) begin
         cyc(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0),
             16'h0080 + 16'($urandom_range(0, 5)), 16'($urandom), 1'($urandom_range(0, 3) == 0));
      end
      repeat (8) cyc(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      for (int i = 128; i < 134; i++) chk($sformatf("final_mem%0d", i), dmem[i], 32'(ref_mem[i]));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
